// File: rtl/i3c_pkg.sv
// Shared IBI types: final status codes, retry-sequencer states, attempt limit.
package i3c_pkg;

  typedef enum logic [1:0] {
    IBI_SUCCESS           = 2'b00,
    IBI_RETRIES_EXHAUSTED = 2'b01,
    IBI_ABORTED           = 2'b10
  } ibi_status_e;

  typedef enum logic [2:0] {
    IBI_IDLE,
    IBI_WAIT_BUS,
    IBI_START,
    IBI_WAIT_RESULT,
    IBI_BACKOFF,
    IBI_REPORT
  } ibi_retry_state_e;

  // retry_num max 7 plus the first attempt
  localparam int unsigned IbiMaxAttempts = 8;

endpackage

// File: rtl/ibi_backoff_timer.sv
// Load/count-down/expire counter that spaces IBI retries by Cycles clocks.
module ibi_backoff_timer #(
  parameter int unsigned Cycles = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = (Cycles < 2) ? 1 : $clog2(Cycles + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CntW'(Cycles);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/ibi_retry_ctrl.sv
// IBI retry sequencer: accept, wait for bus, start, retry on NACK/arb loss, report.
// Optional retry backoff counter enabled by defining IBI_RETRY_BACKOFF_EN.
module ibi_retry_ctrl
  import i3c_pkg::*;
#(
  parameter int unsigned BackoffCycles = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ibi_enable_i,
  input  logic [2:0] ibi_retry_num_i,
  input  logic [6:0] target_ibi_addr_i,
  input  logic       target_ibi_addr_valid_i,
  input  logic       ibi_req_valid_i,
  output logic       ibi_req_ready_o,
  input  logic       bus_available_i,
  output logic       ibi_start_o,
  output logic [6:0] ibi_addr_o,
  input  logic       ibi_ack_i,
  input  logic       ibi_nack_i,
  input  logic       arb_lost_i,
  output logic       ibi_status_valid_o,
  output logic [1:0] ibi_status_o,
  output logic [3:0] ibi_attempts_o
);

  localparam int unsigned AttW = $clog2(IbiMaxAttempts + 1);

  ibi_retry_state_e r_state;
  logic [6:0]       r_addr;
  logic [2:0]       r_retry_num;
  logic [AttW-1:0]  r_attempts;
  logic [AttW-1:0]  r_attempts_o;
  logic             r_start;
  logic             r_status_valid;
  ibi_status_e      r_status;
  logic             w_fail;
  logic             w_bo_done;

  assign ibi_req_ready_o = ~rst_i & (r_state == IBI_IDLE) & ibi_enable_i & target_ibi_addr_valid_i;
  assign w_fail          = ibi_nack_i | arb_lost_i;

`ifdef IBI_RETRY_BACKOFF_EN
  logic w_bo_en;
  logic w_bo_load;

  // Reloaded in every other state, so entry and abort both start from a full count
  assign w_bo_en   = (r_state == IBI_BACKOFF);
  assign w_bo_load = ~w_bo_en;

  ibi_backoff_timer #(
    .Cycles(BackoffCycles)
  ) u_backoff (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_load   (w_bo_load),
    .i_en     (w_bo_en),
    .o_expired(w_bo_done)
  );
`else
  logic w_unused_backoff;
  assign w_unused_backoff = |BackoffCycles;
  assign w_bo_done        = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= IBI_IDLE;
      r_addr         <= '0;
      r_retry_num    <= '0;
      r_attempts     <= '0;
      r_attempts_o   <= '0;
      r_start        <= 1'b0;
      r_status_valid <= 1'b0;
      r_status       <= IBI_SUCCESS;
    end else begin
      r_start        <= 1'b0;
      r_status_valid <= 1'b0;
      case (r_state)
        IBI_IDLE: begin
          if (ibi_req_valid_i && ibi_req_ready_o) begin
            r_addr      <= target_ibi_addr_i;
            r_retry_num <= ibi_retry_num_i;
            r_attempts  <= '0;
            r_state     <= IBI_WAIT_BUS;
          end
        end
        IBI_WAIT_BUS: begin
          if (!ibi_enable_i) begin
            r_state <= IBI_REPORT; r_status_valid <= 1'b1;
            r_status <= IBI_ABORTED; r_attempts_o <= r_attempts;
          end else if (bus_available_i) begin
            // Start pulse and attempt count are registered together on entry to START
            r_state    <= IBI_START;
            r_start    <= 1'b1;
            r_attempts <= r_attempts + 1'b1;
          end
        end
        IBI_START: begin
          r_state <= IBI_WAIT_RESULT;
        end
        IBI_WAIT_RESULT: begin
          if (ibi_ack_i) begin
            r_state <= IBI_REPORT; r_status_valid <= 1'b1;
            r_status <= IBI_SUCCESS; r_attempts_o <= r_attempts;
          end else if (w_fail) begin
            if (r_attempts > AttW'(r_retry_num)) begin
              r_state <= IBI_REPORT; r_status_valid <= 1'b1;
              r_status <= IBI_RETRIES_EXHAUSTED; r_attempts_o <= r_attempts;
            end else if (!ibi_enable_i) begin
              r_state <= IBI_REPORT; r_status_valid <= 1'b1;
              r_status <= IBI_ABORTED; r_attempts_o <= r_attempts;
            end else begin
              r_state <= IBI_BACKOFF;
            end
          end
        end
        IBI_BACKOFF: begin
          if (!ibi_enable_i) begin
            r_state <= IBI_REPORT; r_status_valid <= 1'b1;
            r_status <= IBI_ABORTED; r_attempts_o <= r_attempts;
          end else if (w_bo_done) begin
            r_state <= IBI_WAIT_BUS;
          end
        end
        IBI_REPORT: begin
          r_state <= IBI_IDLE;
        end
        default: begin
          r_state <= IBI_IDLE;
        end
      endcase
    end
  end

  assign ibi_start_o        = r_start;
  assign ibi_addr_o         = r_addr;
  assign ibi_status_valid_o = r_status_valid;
  assign ibi_status_o       = r_status;
  assign ibi_attempts_o     = r_attempts_o;

endmodule

// File: tb/tb_ibi_retry_ctrl.sv
// Scoreboard bench for ibi_retry_ctrl: driver acts as bus/controller, monitor checks each status pulse.
module tb_ibi_retry_ctrl;

  localparam int unsigned BC = 16;
`ifdef IBI_RETRY_BACKOFF_EN
  localparam int RetryGap = BC + 3;
`else
  localparam int RetryGap = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ibi_enable_i = 1'b1;
  logic [2:0] ibi_retry_num_i = '0;
  logic [6:0] target_ibi_addr_i = '0;
  logic       target_ibi_addr_valid_i = 1'b1;
  logic       ibi_req_valid_i = 1'b0;
  logic       ibi_req_ready_o;
  logic       bus_available_i = 1'b1;
  logic       ibi_start_o;
  logic [6:0] ibi_addr_o;
  logic       ibi_ack_i = 1'b0;
  logic       ibi_nack_i = 1'b0;
  logic       arb_lost_i = 1'b0;
  logic       ibi_status_valid_o;
  logic [1:0] ibi_status_o;
  logic [3:0] ibi_attempts_o;

  ibi_retry_ctrl #(.BackoffCycles(BC)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .ibi_enable_i           (ibi_enable_i),
    .ibi_retry_num_i        (ibi_retry_num_i),
    .target_ibi_addr_i      (target_ibi_addr_i),
    .target_ibi_addr_valid_i(target_ibi_addr_valid_i),
    .ibi_req_valid_i        (ibi_req_valid_i),
    .ibi_req_ready_o        (ibi_req_ready_o),
    .bus_available_i        (bus_available_i),
    .ibi_start_o            (ibi_start_o),
    .ibi_addr_o             (ibi_addr_o),
    .ibi_ack_i              (ibi_ack_i),
    .ibi_nack_i             (ibi_nack_i),
    .arb_lost_i             (arb_lost_i),
    .ibi_status_valid_o     (ibi_status_valid_o),
    .ibi_status_o           (ibi_status_o),
    .ibi_attempts_o         (ibi_attempts_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       status;   // 0 success, 1 retries exhausted, 2 aborted
    int       attempts;
    int       starts;
    int       addr;
  } exp_t;

  // abort_mode: 0 none, 1 enable dropped while waiting for the bus, 2 enable dropped with first failure
  typedef struct {
    int  addr;
    int  retry;
    int  nfail;
    bit  arb;
    bit  acknack;
    int  abort_mode;
    int  bus_dly;
    int  gap;
  } scn_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome derived from the protocol rules: each attempt either succeeds or fails;
  // a failure beyond retry_num+1 attempts exhausts, an abort ends with the attempts made.
  function automatic exp_t predict(input scn_t s);
    exp_t e;
    e.addr = s.addr;
    e.status = 0;
    e.attempts = 0;
    if (s.abort_mode == 1) begin
      e.status = 2;
      e.attempts = 0;
    end else begin
      for (int a = 1; a <= 8; a++) begin
        if (a > s.nfail) begin e.status = 0; e.attempts = a; break; end
        if (a > s.retry + 0) begin
          if (a == s.retry + 1) begin e.status = 1; e.attempts = a; break; end
        end
        if (s.abort_mode == 2) begin e.status = 2; e.attempts = a; break; end
      end
    end
    e.starts = e.attempts;
    return e;
  endfunction

  // Monitor: counts start pulses and pops one expectation per status pulse
  initial begin
    int   start_cnt;
    exp_t e;
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        start_cnt = 0;
      end else begin
        if (ibi_start_o) start_cnt++;
        if (ibi_status_valid_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_status", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("status", int'(ibi_status_o), e.status);
            check("attempts", int'(ibi_attempts_o), e.attempts);
            check("start_pulses", start_cnt, e.starts);
            check("addr_at_status", int'(ibi_addr_o), e.addr);
          end
          start_cnt = 0;
        end
      end
    end
  end

  task automatic run(input scn_t s);
    int cyc, k, resp_at, since_fail, ack_cyc;
    bit done;
    @(negedge clk);
    target_ibi_addr_i = 7'(s.addr);
    ibi_retry_num_i   = 3'(s.retry);
    bus_available_i   = (s.bus_dly == 0) && (s.abort_mode != 1);
    check("ready_idle", int'(ibi_req_ready_o), 1);
    ibi_req_valid_i   = 1'b1;
    exp_q.push_back(predict(s));
    cyc = 0; k = 0; resp_at = -1; since_fail = -1; ack_cyc = -1; done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      cyc++;
      if (since_fail >= 0) since_fail++;
      ibi_req_valid_i = 1'b0;
      ibi_ack_i = 1'b0; ibi_nack_i = 1'b0; arb_lost_i = 1'b0;
      if (cyc == 1) ibi_retry_num_i = 3'($urandom);
      if (ibi_status_valid_o) begin
        done = 1'b1;
        if (ack_cyc >= 0) check("ack_to_status", cyc - ack_cyc, 1);
      end else if (ibi_start_o) begin
        k++;
        if (k == 1) check("start_latency", cyc, 2 + s.bus_dly);
        else        check("retry_spacing", since_fail, RetryGap);
        check("addr_hold", int'(ibi_addr_o), s.addr);
        since_fail = -1;
        resp_at = cyc + s.gap;
      end
      if (!done) begin
        // stray result pulse while still waiting for the bus must be ignored
        if (cyc == 1 && (s.bus_dly > 0 || s.abort_mode == 1)) ibi_nack_i = 1'b1;
        if (s.abort_mode != 1 && s.bus_dly > 0 && cyc == 1 + s.bus_dly) bus_available_i = 1'b1;
        if (s.abort_mode == 1 && cyc == 3) ibi_enable_i = 1'b0;
        if (cyc == resp_at) begin
          if (k <= s.nfail) begin
            if (s.arb) arb_lost_i = 1'b1; else ibi_nack_i = 1'b1;
            if (s.abort_mode == 2) ibi_enable_i = 1'b0;
            since_fail = 0;
          end else begin
            ibi_ack_i = 1'b1;
            if (s.acknack) begin ibi_nack_i = 1'b1; arb_lost_i = s.arb; end
            ack_cyc = cyc;
          end
        end
      end
    end
    if (!done) begin
      check("status_timeout", 0, 1);
      exp_q.delete();
    end
    ibi_ack_i = 1'b0; ibi_nack_i = 1'b0; arb_lost_i = 1'b0;
    ibi_enable_i = 1'b1;
    bus_available_i = 1'b1;
  endtask

  function automatic scn_t mk(input int addr, input int retry, input int nfail, input bit arb,
                              input bit acknack, input int abort_mode, input int bus_dly, input int gap);
    scn_t s;
    s.addr = addr; s.retry = retry; s.nfail = nfail; s.arb = arb;
    s.acknack = acknack; s.abort_mode = abort_mode; s.bus_dly = bus_dly; s.gap = gap;
    return s;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errs);
    $fatal(1);
  end

  initial begin
    scn_t s;
    int   r;
    // Reset values
    #2;
    check("rst_ready", int'(ibi_req_ready_o), 0);
    check("rst_start", int'(ibi_start_o), 0);
    check("rst_addr", int'(ibi_addr_o), 0);
    check("rst_status_valid", int'(ibi_status_valid_o), 0);
    check("rst_status", int'(ibi_status_o), 0);
    check("rst_attempts", int'(ibi_attempts_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Address not valid or IBIs disabled: no accept possible
    target_ibi_addr_valid_i = 1'b0;
    #1 check("ready_addr_invalid", int'(ibi_req_ready_o), 0);
    target_ibi_addr_valid_i = 1'b1;
    ibi_enable_i = 1'b0;
    #1 check("ready_disabled", int'(ibi_req_ready_o), 0);
    ibi_enable_i = 1'b1;

    // NACK while idle: nothing happens
    @(negedge clk); ibi_nack_i = 1'b1;
    @(negedge clk); ibi_nack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("idle_nack_no_start", int'(ibi_start_o), 0);
      check("idle_nack_ready", int'(ibi_req_ready_o), 1);
      @(negedge clk);
    end

    // Directed test-plan cases
    run(mk(8'h2A, 0, 0, 1'b0, 1'b0, 0, 0, 1));
    run(mk(8'h15, 2, 9, 1'b0, 1'b0, 0, 0, 2));
    run(mk(8'h7F, 7, 7, 1'b1, 1'b0, 0, 0, 1));
    run(mk(8'h33, 3, 0, 1'b0, 1'b0, 1, 0, 1));
    run(mk(8'h44, 3, 9, 1'b0, 1'b0, 2, 0, 1));
    run(mk(8'h01, 0, 0, 1'b0, 1'b1, 0, 0, 1));
    run(mk(8'h55, 1, 1, 1'b0, 1'b1, 0, 3, 3));

    // Randomised requests
    for (int n = 0; n < 25; n++) begin
      s.addr    = int'($urandom_range(0, 127));
      s.retry   = int'($urandom_range(0, 7));
      s.nfail   = int'($urandom_range(0, 9));
      s.arb     = 1'($urandom);
      s.acknack = 1'($urandom);
      s.bus_dly = int'($urandom_range(0, 3));
      s.gap     = int'($urandom_range(1, 4));
      r = int'($urandom_range(0, 9));
      s.abort_mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      if (s.abort_mode == 2 && s.nfail == 0) s.nfail = 1;
      run(s);
    end

    // Reset during BACKOFF: request dropped, no status
    @(negedge clk);
    target_ibi_addr_i = 7'h11; ibi_retry_num_i = 3'd3; bus_available_i = 1'b1;
    ibi_req_valid_i = 1'b1;
    @(negedge clk); ibi_req_valid_i = 1'b0;
    @(negedge clk);
    check("rstmid_start", int'(ibi_start_o), 1);
    @(negedge clk); ibi_nack_i = 1'b1;
    @(negedge clk); ibi_nack_i = 1'b0; rst = 1'b1;
    #1;
    check("rstmid_ready", int'(ibi_req_ready_o), 0);
    check("rstmid_status_valid", int'(ibi_status_valid_o), 0);
    check("rstmid_addr", int'(ibi_addr_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("post_rst_no_start", int'(ibi_start_o), 0);
    end
    check("post_rst_attempts", int'(ibi_attempts_o), 0);
    check("post_rst_status", int'(ibi_status_o), 0);

    // Normal operation resumes after reset
    run(mk(8'h66, 1, 1, 1'b1, 1'b0, 0, 0, 2));

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
    $finish;
  end

endmodule
